lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
Load/store unit that sits directly downstream of the ALU in the single-cycle core.
- Takes the ALU result as the effective address and rs2 as store data.
- Drives a req/gnt/rvalid data-memory port and stalls the core until the access completes.
- Returns the aligned, sign- or zero-extended load value to writeback.
- Flags misaligned accesses and illegal size encodings without touching memory.

Parameters:
WIDTH, 32, data and address width (only 32 is supported).

Ports:
clk  in  1  core clock
rst  in  1  reset
req_valid  in  1  memory instruction in execute; held high by the core while stall=1
is_store  in  1  1=store, 0=load
funct3  in  3  RISC-V size/sign field: LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101
addr  in  WIDTH  effective address (ALU result)
wdata  in  WIDTH  store data (rs2)
stall  out  1  freeze PC/pipeline
done  out  1  one-cycle completion pulse
err  out  1  misaligned or illegal funct3; valid only with done
rdata_out  out  WIDTH  extended load result; valid with done, held afterwards
mem_req  out  1  memory request
mem_we  out  1  write enable
mem_addr  out  WIDTH  word-aligned address, addr[1:0] forced to 00
mem_be  out  4  byte enables
mem_wdata  out  WIDTH  lane-replicated store data
mem_gnt  in  1  request accepted
mem_rvalid  in  1  read data valid
mem_rdata  in  WIDTH  read data

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: all registered outputs are 0 (mem_req, mem_we, mem_addr, mem_be, mem_wdata, rdata_out, done, err). FSM goes to IDLE.
- stall is combinational: stall = req_valid && state!=DONE. So stall=0 while req_valid=0.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE, req_valid=1:
  - Latch is_store, funct3 and addr[1:0].
  - Legal and aligned access: go to REQ. Next cycle drive mem_req=1 with mem_we, mem_addr, mem_be and mem_wdata registered.
  - Misaligned access (H with addr[0]=1; W with addr[1:0]!=00) or illegal funct3 (011, 110, 111, or 1xx on a store): go straight to DONE with err=1. mem_req is never asserted.
- REQ:
  - Hold all mem_* stable until mem_gnt.
  - On gnt: drop mem_req next cycle.
  - Store on gnt: go to DONE. No rvalid is awaited.
  - Load on gnt with rvalid in the same cycle: capture and go to DONE.
  - Load on gnt without rvalid: go to WAIT.
- WAIT: on mem_rvalid, capture the extended data into rdata_out and go to DONE.
- DONE: done=1 for exactly one cycle, stall=0 so the core advances. Always return to IDLE. req_valid seen in DONE belongs to the next instruction and is ignored until IDLE.
- mem_rvalid is ignored in IDLE, REQ-for-store and DONE. Stale responses are never captured.
- Byte enables:
  - B: 4'b0001 << off
  - H: 4'b0011 << off
  - W: 4'b1111
- Store data:
  - SB: {4{wdata[7:0]}}
  - SH: {2{wdata[15:0]}}
  - SW: wdata
- Load extraction: shift = mem_rdata >> (8*off), then:
  - LB: sign-extend bits [7:0]
  - LBU: zero-extend bits [7:0]
  - LH: sign-extend bits [15:0]
  - LHU: zero-extend bits [15:0]
  - LW: pass through unchanged.
- Latency: minimum load has stall high for 2 cycles (IDLE, REQ with gnt+rvalid) and done in the 3rd cycle. Minimum store is the same. An error has done in the 2nd cycle.
- Reset mid-operation (REQ or WAIT): next edge returns to IDLE with mem_req=0 and outputs zeroed. A later rvalid is ignored.
- rdata_out holds its value until the next completed load. Stores and errors leave it unchanged, apart from reset.

Decomposition:
- lsu_pkg holds:
  - typedef enum logic [1:0] lsu_state_t {IDLE, REQ, WAIT, DONE}
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU
- One combinational sub-module, lsu_align, takes funct3, offset, wdata and mem_rdata. It returns mem_be, mem_wdata, the extended load data and misalign/illegal.
- lsu_ctrl keeps the FSM and all registers.

Test Plan:
- LW addr=0x100; gnt 2 cycles after mem_req; rvalid next cycle with rdata=0xDEADBEEF -> mem_addr=0x100, be=1111, we=0; done pulses once; rdata_out=0xDEADBEEF; stall low only in DONE.
- LB addr=0x103, mem_rdata=0x80FF0000 with gnt and rvalid in the same cycle -> rdata_out=0xFFFFFF80, done in 3rd cycle. LBU, same stimulus -> 0x00000080.
- SH addr=0x202, wdata=0x1234ABCD -> mem_addr=0x200, be=1100, mem_wdata=0xABCDABCD, we=1; done the cycle after gnt with no rvalid needed; rdata_out unchanged.
- LW addr=0x101 and LH addr=0x003 -> err=1 with done in 2nd cycle; mem_req stays 0 throughout.
- rst pulsed while in WAIT, then mem_rvalid=1 with 0x55555555 -> state IDLE, all outputs 0, rdata_out stays 0, no done.
- Back-to-back: LW then SB, req_valid held continuously -> DONE then IDLE before the second request; exactly two done pulses; second access be=0001<<addr[1:0].

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   lsu_state_t : controller FSM states
//   F3_*        : RISC-V funct3 size/sign encodings understood by the LSU
//   f3_illegal  : helper flagging funct3 values the LSU rejects
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Unsigned variants only exist for loads; 011/110/111 are never legal.
    function automatic logic f3_illegal(input logic [2:0] f3, input logic store);
        logic bad;
        bad = 1'b1;
        case (f3)
            F3_B, F3_H, F3_W: bad = 1'b0;
            F3_BU, F3_HU:     bad = store;
            default:          bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit.
// Inputs : funct3, is_store, off (addr[1:0]), wdata (rs2), mem_rdata.
// Outputs: be (byte enables), wdata_rep (lane-replicated store data),
//          load_data (aligned and extended load value),
//          misalign (offset not a multiple of access size), illegal (bad funct3).
module lsu_align
    import lsu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       funct3,
    input  logic             is_store,
    input  logic [1:0]       off,
    input  logic [WIDTH-1:0] wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [3:0]       be,
    output logic [WIDTH-1:0] wdata_rep,
    output logic [WIDTH-1:0] load_data,
    output logic             misalign,
    output logic             illegal
);

    logic [WIDTH-1:0] shifted_s;

    // Bring the addressed byte/halfword down to bit 0 before extension.
    assign shifted_s = mem_rdata >> {off, 3'b000};

    // Size decode: enables, store replication, load extension, alignment.
    always_comb begin
        be        = 4'b0000;
        wdata_rep = '0;
        load_data = '0;
        misalign  = 1'b0;
        illegal   = f3_illegal(funct3, is_store);
        case (funct3)
            F3_B, F3_BU: begin
                be        = 4'b0001 << off;
                wdata_rep = {4{wdata[7:0]}};
                if (funct3 == F3_B) begin
                    load_data = {{24{shifted_s[7]}}, shifted_s[7:0]};
                end else begin
                    load_data = {24'h000000, shifted_s[7:0]};
                end
            end
            F3_H, F3_HU: begin
                be        = 4'b0011 << off;
                wdata_rep = {2{wdata[15:0]}};
                misalign  = off[0];
                if (funct3 == F3_H) begin
                    load_data = {{16{shifted_s[15]}}, shifted_s[15:0]};
                end else begin
                    load_data = {16'h0000, shifted_s[15:0]};
                end
            end
            F3_W: begin
                be        = 4'b1111;
                wdata_rep = wdata;
                load_data = shifted_s;
                misalign  = |off;
            end
            default: begin
                be        = 4'b0000;
                wdata_rep = '0;
                load_data = '0;
                misalign  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller sitting after the ALU of a single-cycle core.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   req_valid, is_store, funct3    : memory instruction from execute
//   addr, wdata                    : effective address, store data (rs2)
//   stall                          : freeze the core while an access is open
//   done, err, rdata_out           : completion pulse, error flag, load result
//   mem_req/we/addr/be/wdata       : registered request to data memory
//   mem_gnt, mem_rvalid, mem_rdata : memory handshake and read data
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic             is_store,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] wdata,
    output logic             stall,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] rdata_out,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [3:0]       mem_be,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_gnt,
    input  logic             mem_rvalid,
    input  logic [WIDTH-1:0] mem_rdata
);

    lsu_state_t       state_q, state_d;
    logic             is_store_q, is_store_d;
    logic [2:0]       f3_q, f3_d;
    logic [1:0]       off_q, off_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]       mem_be_q, mem_be_d;
    logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [2:0]       al_f3_s;
    logic             al_store_s;
    logic [1:0]       al_off_s;
    logic [3:0]       al_be_s;
    logic [WIDTH-1:0] al_wdata_s;
    logic [WIDTH-1:0] al_load_s;
    logic             al_misalign_s;
    logic             al_illegal_s;

    // In IDLE the aligner sees the live instruction so the request can be
    // registered on the accepting edge; afterwards it sees the latched copy
    // so read data is extracted with the access's own size and offset.
    assign al_f3_s    = (state_q == IDLE) ? funct3   : f3_q;
    assign al_store_s = (state_q == IDLE) ? is_store : is_store_q;
    assign al_off_s   = (state_q == IDLE) ? addr[1:0] : off_q;

    lsu_align #(.WIDTH(WIDTH)) u_align (
        .funct3    (al_f3_s),
        .is_store  (al_store_s),
        .off       (al_off_s),
        .wdata     (wdata),
        .mem_rdata (mem_rdata),
        .be        (al_be_s),
        .wdata_rep (al_wdata_s),
        .load_data (al_load_s),
        .misalign  (al_misalign_s),
        .illegal   (al_illegal_s)
    );

    // Next-state and next-output logic for the access FSM.
    always_comb begin
        state_d     = state_q;
        is_store_d  = is_store_q;
        f3_d        = f3_q;
        off_d       = off_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    is_store_d = is_store;
                    f3_d       = funct3;
                    off_d      = addr[1:0];
                    if (al_misalign_s || al_illegal_s) begin
                        // Rejected without ever touching memory.
                        state_d = DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d     = REQ;
                        mem_req_d   = 1'b1;
                        mem_we_d    = is_store;
                        mem_addr_d  = {addr[WIDTH-1:2], 2'b00};
                        mem_be_d    = al_be_s;
                        mem_wdata_d = al_wdata_s;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    mem_req_d = 1'b0;
                    if (is_store_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (mem_rvalid) begin
                        rdata_d = al_load_s;
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end else begin
                    state_d = REQ;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    rdata_d = al_load_s;
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            DONE: begin
                // Any req_valid seen here belongs to the next instruction.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            is_store_q  <= 1'b0;
            f3_q        <= 3'b000;
            off_q       <= 2'b00;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            is_store_q  <= is_store_d;
            f3_q        <= f3_d;
            off_q       <= off_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // The core only advances in the DONE cycle.
    assign stall     = req_valid && (state_q != DONE);
    assign done      = done_q;
    assign err       = err_q;
    assign rdata_out = rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic        err;
    logic [31:0] rdata_out;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_rdata = 32'h0;

    lsu_ctrl #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .is_store(is_store),
        .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall),
        .done(done), .err(err), .rdata_out(rdata_out), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model (from the access rules) ----------------
    function automatic bit m_legal(input bit st, input logic [2:0] f3);
        return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) ||
               (!st && ((f3 == 3'd4) || (f3 == 3'd5)));
    endfunction

    function automatic int m_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [1:0] off);
        int n = m_size(f3);
        int v = ((1 << n) - 1) << off;
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] w);
        logic [31:0] r = 32'h0;
        int n = m_size(f3);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] d);
        logic [31:0] sh = d >> (8 * off);
        logic [31:0] mask;
        logic [31:0] v;
        int n = m_size(f3);
        if (n == 4) return sh;
        mask = (32'h1 << (8 * n)) - 32'h1;
        v = sh & mask;
        if (!f3[2] && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    // One complete access. Starts with inputs driven in IDLE, or in the DONE
    // cycle of the previous access when from_done is set; ends in DONE.
    task automatic run_access(input bit st, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input int gd, input int rd,
                              input logic [31:0] rdat, input bit from_done);
        bit aligned;
        bit bad;
        req_valid = 1'b1;
        is_store  = st;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        #1;
        if (from_done) begin
            step();
            chk("b2b_idle_done", {31'd0, done}, 32'd0);
        end
        chk("idle_stall", {31'd0, stall}, 32'd1);
        chk("idle_req", {31'd0, mem_req}, 32'd0);
        aligned = (a[1:0] % m_size(f3)) == 0;
        bad = !m_legal(st, f3) || !aligned;
        if (bad) begin
            step();
            chk("err_done", {31'd0, done}, 32'd1);
            chk("err_flag", {31'd0, err}, 32'd1);
            chk("err_noreq", {31'd0, mem_req}, 32'd0);
            chk("err_stall", {31'd0, stall}, 32'd0);
            chk("err_rdata", rdata_out, exp_rdata);
            return;
        end
        step();
        chk("req_req", {31'd0, mem_req}, 32'd1);
        chk("req_we", {31'd0, mem_we}, {31'd0, st});
        chk("req_addr", mem_addr, {a[31:2], 2'b00});
        chk("req_be", {28'd0, mem_be}, {28'd0, m_be(f3, a[1:0])});
        if (st) chk("req_wdata", mem_wdata, m_wdata(f3, wd));
        chk("req_stall", {31'd0, stall}, 32'd1);
        for (int k = 0; k < gd; k++) begin
            step();
            chk("hold_req", {31'd0, mem_req}, 32'd1);
            chk("hold_done", {31'd0, done}, 32'd0);
        end
        mem_gnt = 1'b1;
        if (st || rd == 0) begin
            // A response beside a store grant must be ignored.
            mem_rvalid = 1'b1;
            mem_rdata  = st ? $urandom : rdat;
        end
        step();
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        if (!st && rd > 0) begin
            chk("wait_req", {31'd0, mem_req}, 32'd0);
            chk("wait_done", {31'd0, done}, 32'd0);
            chk("wait_stall", {31'd0, stall}, 32'd1);
            for (int k = 1; k < rd; k++) begin
                step();
                chk("wait_idle", {31'd0, done}, 32'd0);
            end
            mem_rvalid = 1'b1;
            mem_rdata  = rdat;
            step();
            mem_rvalid = 1'b0;
        end
        if (!st) exp_rdata = m_load(f3, a[1:0], rdat);
        chk("fin_done", {31'd0, done}, 32'd1);
        chk("fin_err", {31'd0, err}, 32'd0);
        chk("fin_stall", {31'd0, stall}, 32'd0);
        chk("fin_req", {31'd0, mem_req}, 32'd0);
        chk("fin_rdata", rdata_out, exp_rdata);
    endtask

    task automatic finish_idle();
        mem_rvalid = 1'b1;
        mem_rdata  = $urandom;
        req_valid  = 1'b0;
        step();
        mem_rvalid = 1'b0;
        chk("post_done", {31'd0, done}, 32'd0);
        chk("post_stall", {31'd0, stall}, 32'd0);
        chk("post_rdata", rdata_out, exp_rdata);
    endtask

    initial begin
        bit prev_hold;
        bit hold;
        rst = 1'b1; req_valid = 1'b0; is_store = 1'b0; funct3 = 3'd0;
        addr = 32'h0; wdata = 32'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        step();
        step();
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_be", {28'd0, mem_be}, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_rdata", rdata_out, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        rst = 1'b0;
        step();

        // LW with delayed grant and response.
        run_access(1'b0, 3'b010, 32'h100, 32'h0, 2, 1, 32'hDEADBEEF, 1'b0);
        chk("lw_val", rdata_out, 32'hDEADBEEF);
        finish_idle();
        // LB / LBU at the top byte lane, grant and response together.
        run_access(1'b0, 3'b000, 32'h103, 32'h0, 0, 0, 32'h80FF0000, 1'b0);
        chk("lb_val", rdata_out, 32'hFFFFFF80);
        finish_idle();
        run_access(1'b0, 3'b100, 32'h103, 32'h0, 0, 0, 32'h80FF0000, 1'b0);
        chk("lbu_val", rdata_out, 32'h00000080);
        finish_idle();
        // SH upper half.
        run_access(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 1, 0, 32'h0, 1'b0);
        chk("sh_be", {28'd0, mem_be}, 32'hC);
        chk("sh_wdata", mem_wdata, 32'hABCDABCD);
        chk("sh_rdata_kept", rdata_out, 32'h00000080);
        finish_idle();
        // Misaligned accesses.
        run_access(1'b0, 3'b010, 32'h101, 32'h0, 0, 0, 32'h0, 1'b0);
        finish_idle();
        run_access(1'b0, 3'b001, 32'h003, 32'h0, 0, 0, 32'h0, 1'b0);
        finish_idle();

        // Reset while waiting for read data; a late response must be dropped.
        req_valid = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h40;
        step();
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        chk("rw_inwait", {31'd0, stall}, 32'd1);
        rst = 1'b1;
        req_valid = 1'b0;
        step();
        rst = 1'b0;
        exp_rdata = 32'h0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h55555555;
        step();
        mem_rvalid = 1'b0;
        chk("rw_req", {31'd0, mem_req}, 32'd0);
        chk("rw_addr", mem_addr, 32'd0);
        chk("rw_be", {28'd0, mem_be}, 32'd0);
        chk("rw_rdata", rdata_out, 32'd0);
        chk("rw_done", {31'd0, done}, 32'd0);
        step();
        chk("rw_done2", {31'd0, done}, 32'd0);

        // Back-to-back LW then SB with req_valid held.
        run_access(1'b0, 3'b010, 32'h300, 32'h0, 0, 1, 32'h01020304, 1'b0);
        run_access(1'b1, 3'b000, 32'h302, 32'hA5A5A577, 0, 0, 32'h0, 1'b1);
        chk("b2b_be", {28'd0, mem_be}, 32'h4);
        chk("b2b_rdata", rdata_out, 32'h01020304);
        finish_idle();

        // Randomized accesses, some back-to-back.
        prev_hold = 1'b0;
        for (int i = 0; i < 60; i++) begin
            logic [2:0] f3r;
            f3r = 3'($urandom_range(0, 7));
            run_access(1'($urandom_range(0, 1)), f3r, $urandom, $urandom,
                       $urandom_range(0, 3), $urandom_range(0, 3), $urandom, prev_hold);
            hold = 1'($urandom_range(0, 1));
            if (!hold) finish_idle();
            prev_hold = hold;
        end
        if (prev_hold) finish_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
